pipeline_run_monitor: RTL and testbench
=======================================

Name: pipeline_run_monitor

Overview:
- Synthesisable run controller and performance monitor for the pipelined RISC-V core.
- Sequences the core's active-low reset after a start request.
- While the core runs, counts cycles, stall cycles and flush cycles.
- Detects program completion (PC stuck with no stall) or a cycle-budget timeout, then freezes results for readout.

Parameters:
- ADDR_W, 32, width of the observed fetch PC.
- CNT_W, 32, width of every performance counter.
- RST_HOLD, 4, cycles core_rst_n is held low before the run starts (≥1).
- HALT_WIN, 8, consecutive non-stalled cycles with unchanged PC that declare a halt (≥2).
- MAX_CYCLES, 0, run-cycle budget; 0 = unlimited.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- pc_i  in  ADDR_W  core fetch PC (PCF).
- stall_i  in  1  core StallF.
- flush_i  in  1  core branch/jump flush.
- core_rst_n  out  1  drives the core's rst_n.
- busy  out  1  high in RESET_HOLD or RUN.
- done  out  1  high in DONE.
- halted  out  1  run ended by halt detection.
- timeout  out  1  run ended by cycle budget.
- halt_pc  out  ADDR_W  PC captured when the run ended.
- cycle_cnt  out  CNT_W  RUN cycles.
- stall_cnt  out  CNT_W  RUN cycles with stall_i=1.
- flush_cnt  out  CNT_W  RUN cycles with flush_i=1.

Behaviour:
- Reset values: state=IDLE; core_rst_n=0; busy=0; done=0; halted=0; timeout=0; halt_pc=0; all counters 0. Reset applies from any state, mid-run included.
- FSM: IDLE, RESET_HOLD, RUN, DONE.
- IDLE:
  - core_rst_n=0.
  - start=1 -> RESET_HOLD next cycle.
  - On that transition: all counters, flags and halt_pc cleared, and hold_cnt=0.
- RESET_HOLD:
  - core_rst_n=0 and hold_cnt increments each cycle.
  - When hold_cnt==RST_HOLD-1 -> RUN, giving exactly RST_HOLD low cycles.
  - start is ignored.
- RUN:
  - core_rst_n=1 (registered output, no glitch).
  - Each cycle: cycle_cnt+1; stall_cnt+1 if stall_i; flush_cnt+1 if flush_i.
  - Counters saturate at all-ones and never wrap.
  - Stuck-PC tracker:
    - prev_pc is registered each RUN cycle.
    - same_cnt+1 when pc_i==prev_pc and stall_i=0; otherwise same_cnt=0.
    - On the first RUN cycle, same_cnt=0 regardless of pc_i.
  - Halt condition: same_cnt reaches HALT_WIN-1 while the current cycle also matches. -> DONE, halted=1, halt_pc=pc_i.
  - Timeout condition: MAX_CYCLES≠0 and cycle_cnt==MAX_CYCLES-1 in this cycle. -> DONE, timeout=1, halt_pc=pc_i.
  - If both conditions hold in the same cycle, both flags are set.
  - The final RUN cycle is still counted.
  - start is ignored.
- DONE:
  - done=1, busy=0, core_rst_n=1; counters, flags and halt_pc frozen.
  - start=1 -> RESET_HOLD with the same clearing as from IDLE.
- Stalled cycles never advance the halt tracker, so a long load-use stall sequence cannot fake a halt.

Optional Feature:
- Macro: PPWHU_STALL_RUN_EN.
- Defined:
  - Adds output max_stall_run [CNT_W]: longest run of consecutive stall_i=1 cycles seen in RUN.
  - Reset value 0; cleared on entry to RESET_HOLD; saturating.
  - A run still open when RUN ends is included in the final value.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ppwhu_mon_pkg holds:
  - state enum: IDLE=2'd0, RESET_HOLD=2'd1, RUN=2'd2, DONE=2'd3;
  - end-reason bit positions;
  - the saturation constant function.
- One sub-module, sat_counter, instantiated three times (four with the macro): inputs clr and inc; parameter width; holds at max.

Test Plan:
- Reset and hold: rst high 3 cycles, then start pulse at cycle 5 -> core_rst_n=0 through cycle 9, 1 from cycle 10; busy=1 from cycle 6.
- Halt: PC increments by 4 from 0x0 to 0x20, then stays at 0x20 with stall_i=0 -> done after 8 equal cycles; halted=1; halt_pc=0x20; cycle_cnt exact.
- Stall masking: PC held at 0x10 for 12 cycles with stall_i=1 -> no halt, stall_cnt=12; release stall with PC still stuck -> halt 8 cycles later.
- Timeout: MAX_CYCLES=20, PC always changing -> done at the 20th RUN cycle; timeout=1, halted=0, cycle_cnt=20.
- Simultaneous ending and restart: halt and budget coincide -> halted=1 and timeout=1. A start in DONE clears counters and core_rst_n drops for 4 cycles. rst asserted mid-RUN -> IDLE, all outputs return to reset values.
- Saturation with CNT_W=4: 20 RUN cycles -> cycle_cnt=15, no wrap.

Source files
------------

// File: rtl/pipeline_run_monitor_pkg.sv
// Shared types and helpers for the pipeline run monitor.
// State encoding, end-reason bit positions and saturation limit.
package ppwhu_mon_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam int END_HALT    = 0;
    localparam int END_TIMEOUT = 1;
    localparam int END_W       = 2;

    // All-ones value of a w-bit counter, widened to 64 bits.
    function automatic logic [63:0] sat_max(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pipeline_run_monitor_if.sv
// Core-side observation and result bus of the run monitor.
// PPWHU_STALL_RUN_EN adds the max_stall_run result signal.
interface pipeline_run_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              start;
    logic [ADDR_W-1:0] pc_i;
    logic              stall_i;
    logic              flush_i;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              halted;
    logic              timeout;
    logic [ADDR_W-1:0] halt_pc;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`ifdef PPWHU_STALL_RUN_EN
    logic [CNT_W-1:0]  max_stall_run;
`endif

    modport master (
        output start, pc_i, stall_i, flush_i,
        input  core_rst_n, busy, done, halted, timeout,
        input  halt_pc, cycle_cnt, stall_cnt, flush_cnt
`ifdef PPWHU_STALL_RUN_EN
        , input max_stall_run
`endif
    );

    modport slave (
        input  start, pc_i, stall_i, flush_i,
        output core_rst_n, busy, done, halted, timeout,
        output halt_pc, cycle_cnt, stall_cnt, flush_cnt
`ifdef PPWHU_STALL_RUN_EN
        , output max_stall_run
`endif
    );

endinterface

// File: rtl/pipeline_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
    import ppwhu_mon_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_max(WIDTH));

    // Count up on inc, stick at the maximum, clear wins over inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_run_monitor.sv
// Run controller and performance monitor for the pipelined core.
// Optional PPWHU_STALL_RUN_EN tracks the longest stall run.
module pipeline_run_monitor
    import ppwhu_mon_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int RST_HOLD   = 4,
    parameter int HALT_WIN   = 8,
    parameter int MAX_CYCLES = 0
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_run_monitor_if.slave bus
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int SW = $clog2(HALT_WIN + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0] HALT_LAST = SW'(HALT_WIN - 1);
    localparam logic [63:0] BUDGET_LAST =
        64'(MAX_CYCLES) - 64'd1;

    state_t            state;
    state_t            state_nx;
    logic [HW-1:0]     hold_cnt;
    logic [ADDR_W-1:0] prev_pc;
    logic [SW-1:0]     same_cnt;
    logic              armed;
    logic              clr;
    logic              in_run;
    logic              match;
    logic              halt_hit;
    logic              time_hit;
    logic              core_rst_q;
    logic [END_W-1:0]  reason;
    logic [ADDR_W-1:0] end_pc;

    assign in_run = (state == RUN);

    // Same PC as last RUN cycle and not stalled; never on the first cycle.
    assign match = armed && !bus.stall_i && (bus.pc_i == prev_pc);

    assign halt_hit = in_run && match && (same_cnt == HALT_LAST);

    assign time_hit = (MAX_CYCLES != 0) && in_run &&
                      (64'(bus.cycle_cnt) == BUDGET_LAST);

    // Next-state logic; clr marks entry into RESET_HOLD.
    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx = RESET_HOLD;
                    clr      = 1'b1;
                end
            end
            RESET_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (halt_hit || time_hit) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Core reset is registered from the next state so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_q <= 1'b0;
        end else begin
            core_rst_q <= (state_nx == RUN) || (state_nx == DONE);
        end
    end

    // Length of the core reset pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (clr) begin
            hold_cnt <= '0;
        end else if (state == RESET_HOLD) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // Stuck-PC tracker; stalled cycles reset the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pc  <= '0;
            same_cnt <= '0;
            armed    <= 1'b0;
        end else if (clr) begin
            same_cnt <= '0;
            armed    <= 1'b0;
        end else if (in_run) begin
            prev_pc  <= bus.pc_i;
            armed    <= 1'b1;
            same_cnt <= match ? same_cnt + SW'(1) : '0;
        end
    end

    // End reason and PC captured on the final RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            reason <= '0;
            end_pc <= '0;
        end else if (clr) begin
            reason <= '0;
            end_pc <= '0;
        end else if (halt_hit || time_hit) begin
            reason[END_HALT]    <= halt_hit;
            reason[END_TIMEOUT] <= time_hit;
            end_pc              <= bus.pc_i;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cycle (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (in_run),
        .cnt (bus.cycle_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (in_run && bus.stall_i),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (in_run && bus.flush_i),
        .cnt (bus.flush_cnt)
    );

`ifdef PPWHU_STALL_RUN_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] stall_run;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] max_run;

    sat_counter #(.WIDTH(CNT_W)) u_stall_run (
        .clk (clk),
        .rst (rst),
        .clr (clr || (in_run && !bus.stall_i)),
        .inc (in_run && bus.stall_i),
        .cnt (stall_run)
    );

    // Length of the current stall run including this cycle.
    assign run_len = (stall_run == CNT_MAX) ?
                     stall_run : stall_run + CNT_W'(1);

    // Track the longest run, updated while the run is still open.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_run <= '0;
        end else if (clr) begin
            max_run <= '0;
        end else if (in_run && bus.stall_i && (run_len > max_run)) begin
            max_run <= run_len;
        end
    end

    assign bus.max_stall_run = max_run;
`endif

    assign bus.core_rst_n = core_rst_q;
    assign bus.busy       = (state == RESET_HOLD) || (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.halted     = reason[END_HALT];
    assign bus.timeout    = reason[END_TIMEOUT];
    assign bus.halt_pc    = end_pc;

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Scoreboard bench for pipeline_run_monitor.
// Three instances: default, 20-cycle budget, 4-bit counters.
module tb_pipeline_run_monitor;

    typedef struct {
        logic        halted;
        logic        timeout;
        logic [31:0] pc;
        logic [31:0] cyc;
        logic [31:0] stl;
        logic [31:0] fls;
        logic [31:0] msr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        start_c;
    logic [31:0] pc;
    logic        stall;
    logic        flush;

    int checks;
    int failures;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic done_a;
    logic done_b;
    logic done_c;

    logic [31:0] msr_a;
    logic [31:0] msr_b;
    logic [31:0] msr_c;

    pipeline_run_monitor_if #(.ADDR_W(32), .CNT_W(32)) ifa ();
    pipeline_run_monitor_if #(.ADDR_W(32), .CNT_W(32)) ifb ();
    pipeline_run_monitor_if #(.ADDR_W(32), .CNT_W(4))  ifc ();

    assign ifa.start   = start_a;
    assign ifa.pc_i    = pc;
    assign ifa.stall_i = stall;
    assign ifa.flush_i = flush;
    assign ifb.start   = start_b;
    assign ifb.pc_i    = pc;
    assign ifb.stall_i = stall;
    assign ifb.flush_i = flush;
    assign ifc.start   = start_c;
    assign ifc.pc_i    = pc;
    assign ifc.stall_i = stall;
    assign ifc.flush_i = flush;

`ifdef PPWHU_STALL_RUN_EN
    assign msr_a = ifa.max_stall_run;
    assign msr_b = ifb.max_stall_run;
    assign msr_c = 32'(ifc.max_stall_run);
`else
    assign msr_a = '0;
    assign msr_b = '0;
    assign msr_c = '0;
`endif

    pipeline_run_monitor dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pipeline_run_monitor #(.MAX_CYCLES(20)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    pipeline_run_monitor #(.CNT_W(4)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic h, input logic t,
                                input logic [31:0] p,
                                input logic [31:0] c,
                                input logic [31:0] s,
                                input logic [31:0] f,
                                input logic [31:0] m);
        exp_t e;
        e.halted  = h;
        e.timeout = t;
        e.pc      = p;
        e.cyc     = c;
        e.stl     = s;
        e.fls     = f;
        e.msr     = m;
        return e;
    endfunction

    task automatic chk_end(input string t, input exp_t e,
                           input logic h, input logic tm,
                           input logic [31:0] p,
                           input logic [31:0] c,
                           input logic [31:0] s,
                           input logic [31:0] f,
                           input logic [31:0] m);
        chk({t, "_halted"},  32'(h),  32'(e.halted));
        chk({t, "_timeout"}, 32'(tm), 32'(e.timeout));
        chk({t, "_halt_pc"}, p, e.pc);
        chk({t, "_cycles"},  c, e.cyc);
        chk({t, "_stalls"},  s, e.stl);
        chk({t, "_flushes"}, f, e.fls);
`ifdef PPWHU_STALL_RUN_EN
        chk({t, "_max_stall_run"}, m, e.msr);
`else
        if (m !== 32'd0) begin
            chk({t, "_msr_absent"}, m, 32'd0);
        end
`endif
    endtask

    task automatic unexpected(input string t);
        checks++;
        failures++;
        $display("FAIL %s_unexpected_done actual=done required=none", t);
    endtask

    // Monitor: compare each DUT's results on the rising edge of done.
    always @(negedge clk) begin
        if (ifa.done && !done_a) begin
            if (qa.size() == 0) unexpected("a");
            else chk_end("a", qa.pop_front(), ifa.halted, ifa.timeout,
                         ifa.halt_pc, ifa.cycle_cnt, ifa.stall_cnt,
                         ifa.flush_cnt, msr_a);
        end
        if (ifb.done && !done_b) begin
            if (qb.size() == 0) unexpected("b");
            else chk_end("b", qb.pop_front(), ifb.halted, ifb.timeout,
                         ifb.halt_pc, ifb.cycle_cnt, ifb.stall_cnt,
                         ifb.flush_cnt, msr_b);
        end
        if (ifc.done && !done_c) begin
            if (qc.size() == 0) unexpected("c");
            else chk_end("c", qc.pop_front(), ifc.halted, ifc.timeout,
                         ifc.halt_pc, 32'(ifc.cycle_cnt),
                         32'(ifc.stall_cnt), 32'(ifc.flush_cnt), msr_c);
        end
        done_a <= ifa.done;
        done_b <= ifb.done;
        done_c <= ifc.done;
    end

    task automatic step(input logic [31:0] p,
                        input logic s, input logic f);
        pc    = p;
        stall = s;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ctl(input int w);
        case (w)
            0:       return {ifa.core_rst_n, ifa.busy};
            1:       return {ifb.core_rst_n, ifb.busy};
            default: return {ifc.core_rst_n, ifc.busy};
        endcase
    endfunction

    // Pulse start, then check the core reset is low for exactly 4 cycles.
    task automatic launch(input int w);
        logic [1:0] v;
        start_a = (w == 0);
        start_b = (w == 1);
        start_c = (w == 2);
        step(32'h0, 1'b0, 1'b0);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = ctl(w);
            chk($sformatf("hold%0d_w%0d_core_rst_n", i, w), 32'(v[1]), 32'd0);
            chk($sformatf("hold%0d_w%0d_busy", i, w), 32'(v[0]), 32'd1);
            step(32'h0, 1'b0, 1'b0);
        end
        v = ctl(w);
        chk($sformatf("run_w%0d_core_rst_n", w), 32'(v[1]), 32'd1);
        chk($sformatf("run_w%0d_busy", w), 32'(v[0]), 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done_a   = 1'b0;
        done_b   = 1'b0;
        done_c   = 1'b0;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        pc       = '0;
        stall    = 1'b0;
        flush    = 1'b0;

        for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0);
        chk("rst_core_rst_n", 32'(ifa.core_rst_n), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_cycle_cnt", ifa.cycle_cnt, 32'd0);
        rst = 1'b0;
        step(32'h0, 1'b0, 1'b0);

        // Halt: PC climbs to 0x20 then sticks.
        qa.push_back(mk(1'b1, 1'b0, 32'h20, 32'd17, 32'd0, 32'd2, 32'd0));
        launch(0);
        for (int k = 0; k < 17; k++) begin
            step((k < 9) ? 32'(4 * k) : 32'h20, 1'b0,
                 (k == 2) || (k == 5));
        end
        for (int k = 0; k < 3; k++) step(32'(100 + k), 1'b1, 1'b1);
        chk("halt_frozen_cycles", ifa.cycle_cnt, 32'd17);
        chk("halt_done_level", 32'(ifa.done), 32'd1);
        chk("halt_done_busy", 32'(ifa.busy), 32'd0);

        // Stall masking: restart from DONE, stuck PC under stall.
        qa.push_back(mk(1'b1, 1'b0, 32'h10, 32'd24, 32'd12, 32'd0, 32'd12));
        launch(0);
        chk("restart_a_cycles", ifa.cycle_cnt, 32'd0);
        chk("restart_a_halted", 32'(ifa.halted), 32'd0);
        for (int k = 0; k < 16; k++) begin
            step((k < 4) ? 32'(4 * k) : 32'h10, k >= 4, 1'b0);
        end
        chk("stall_no_halt", 32'(ifa.done), 32'd0);
        chk("stall_cnt_mid", ifa.stall_cnt, 32'd12);
        for (int k = 16; k < 24; k++) step(32'h10, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);

        // Timeout: PC always moving, 20-cycle budget.
        qb.push_back(mk(1'b0, 1'b1, 32'h4c, 32'd20, 32'd1, 32'd3, 32'd1));
        launch(1);
        for (int k = 0; k < 20; k++) begin
            step(32'(4 * k), k == 10, (k == 3) || (k == 4) || (k == 7));
        end
        step(32'h0, 1'b0, 1'b0);

        // Halt and budget land on the same cycle.
        qb.push_back(mk(1'b1, 1'b1, 32'h2c, 32'd20, 32'd0, 32'd0, 32'd0));
        launch(1);
        for (int k = 0; k < 20; k++) begin
            step((k < 12) ? 32'(4 * k) : 32'h2c, 1'b0, 1'b0);
        end
        step(32'h0, 1'b0, 1'b0);

        // Saturation with 4-bit counters.
        qc.push_back(mk(1'b1, 1'b0, 32'h100, 32'd15, 32'd15, 32'd15, 32'd15));
        launch(2);
        for (int k = 0; k < 29; k++) begin
            step((k < 20) ? 32'(4 * k) : 32'h100, k < 20, k < 20);
        end
        step(32'h0, 1'b0, 1'b0);

        // Restart from DONE, then reset mid-RUN.
        launch(1);
        chk("restart_b_cycles", ifb.cycle_cnt, 32'd0);
        chk("restart_b_timeout", 32'(ifb.timeout), 32'd0);
        chk("restart_b_halt_pc", ifb.halt_pc, 32'd0);
        for (int k = 0; k < 5; k++) step(32'(8 * k), 1'b0, 1'b0);
        chk("midrun_cycles", ifb.cycle_cnt, 32'd5);
        rst = 1'b1;
        step(32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst_core_rst_n", 32'(ifb.core_rst_n), 32'd0);
        chk("midrst_busy", 32'(ifb.busy), 32'd0);
        chk("midrst_cycles", ifb.cycle_cnt, 32'd0);
        chk("midrst_a_done", 32'(ifa.done), 32'd0);
        chk("midrst_a_halted", 32'(ifa.halted), 32'd0);
        chk("midrst_a_halt_pc", ifa.halt_pc, 32'd0);
        chk("midrst_a_stalls", ifa.stall_cnt, 32'd0);
        for (int k = 0; k < 3; k++) step(32'h0, 1'b0, 1'b0);

        while (qa.size() > 0) begin
            void'(qa.pop_front());
            checks++;
            failures++;
            $display("FAIL a_missing_done actual=none required=done");
        end
        while (qb.size() > 0) begin
            void'(qb.pop_front());
            checks++;
            failures++;
            $display("FAIL b_missing_done actual=none required=done");
        end
        while (qc.size() > 0) begin
            void'(qc.pop_front());
            checks++;
            failures++;
            $display("FAIL c_missing_done actual=none required=done");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
